mult_issue: RTL
===============

MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before abort.
REQ-003 SHALL have ports: clk in 1 clock; reset_n in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; in_a in 32; in_b in 32; in_tag in 4 (operand request).
REQ-005 SHALL have ports: mul_start out 1; mul_a out 32; mul_b out 32 (drive to downstream sequential multiplier).
REQ-006 SHALL have ports: mul_done in 1 (level); mul_product in 64 (multiplier result).
REQ-007 SHALL have ports: res_valid out 1; res_ready in 1; res_product out 64; res_tag out 4; res_err out 1 (result).

Function
REQ-008 SHALL accept a request on a clk edge with in_valid&&in_ready; in_ready = FIFO not full.
REQ-009 SHALL store {a,b,tag} in a DEPTH-entry FIFO with wrapping pointers and a count 0..DEPTH; push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-010 SHALL implement FSM IDLE, START, SETTLE, WAIT.
REQ-011 IDLE->START SHALL occur when FIFO non-empty and (res_valid==0 or res_ready==1); on that edge SHALL pop head into mul_a/mul_b/tag registers.
REQ-012 mul_start SHALL be 1 exactly during START (one cycle); mul_a/mul_b SHALL hold stable from START until the next pop.
REQ-013 START->SETTLE unconditionally; SETTLE->WAIT unconditionally; mul_done SHALL be ignored in START and SETTLE.
REQ-014 In WAIT, on first cycle mul_done==1, SHALL capture mul_product into res_product, tag into res_tag, res_err=0, set res_valid=1, go IDLE.
REQ-015 WAIT SHALL count cycles from 0; when the count reaches TIMEOUT-1 with mul_done==0 SHALL set res_valid=1, res_err=1, res_product=0, go IDLE.
REQ-016 res_valid SHALL clear on an edge with res_ready==1 unless a new capture occurs that edge; res_* SHALL be stable while res_valid&&!res_ready.
REQ-017 Latency: request into empty idle block with res free -> mul_start 1 cycle after acceptance; res_valid the cycle after mul_done is seen in WAIT.
REQ-018 Results SHALL emerge in request order; one operation in flight at a time.
REQ-019 A new request arriving while FSM is busy SHALL be queued, never dropped while in_ready==1.

Reset
REQ-020 Reset SHALL force: FSM IDLE, FIFO count/pointers 0, in_ready 1, mul_start 0, mul_a/mul_b 0, res_valid 0, res_product 0, res_tag 0, res_err 0, WAIT counter 0.
REQ-021 Reset mid-operation SHALL discard FIFO contents and in-flight operation; no result emitted for them.

Structure
REQ-022 State enum, 64-bit product width and 4-bit tag width SHALL live in shared package mult_pkg.
REQ-023 The FIFO SHALL be a separate sub-module mult_op_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-024 Single op: a=3,b=5,tag=1, model done 34 cycles after start with product 15 -> one mul_start pulse, res_product=15, res_tag=1, res_err=0.
REQ-025 Back-to-back: 5 requests, DEPTH=4, multiplier busy -> in_ready low after 4 queued (5th stalls), all 5 results in order with correct tags.
REQ-026 Backpressure: res_ready=0 for 20 cycles with FIFO non-empty -> no mul_start while res_valid; res_* stable; next start the cycle after res_ready=1 handshake.
REQ-027 Timeout: mul_done held 0 -> res_valid=1, res_err=1, res_product=0 after TIMEOUT WAIT cycles; next queued op then issues normally.
REQ-028 Stale done: mul_done held 1 continuously -> capture occurs in WAIT (3rd cycle after START), never in START/SETTLE.
REQ-029 Reset mid-WAIT with 2 queued -> all outputs at reset values, no res_valid after reset release until new request.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the multiply-issue block.
//   DATA_W / PROD_W / TAG_W : operand, product and tag widths
//   state_e                 : issue FSM states
//   op_t                    : one queued request {a, b, tag}
package mult_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int TAG_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } op_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand FIFO for mult_issue: DEPTH entries of op_t, wrapping pointers,
// occupancy count 0..DEPTH.
//   clk, reset_n        : clock, async active-low reset
//   push, push_data     : write one entry (accepted when not full, or when a
//                         pop happens in the same cycle)
//   pop, pop_data       : pop_data is the head; pop removes it (ignored when empty)
//   full, empty, count  : occupancy status
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  op_t                    push_data,
  input  logic                   pop,
  output op_t                    pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  op_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_en, pop_en;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same
  // cycle; the head is read out before the overwrite lands.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map to plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mult_issue.sv
// Queues multiply requests and issues them one at a time to a downstream
// sequential multiplier, returning results in request order with a timeout
// guard on the multiplier.
//   clk, reset_n                         : clock, async active-low reset
//   in_valid/in_ready/in_a/in_b/in_tag   : request handshake (ready = FIFO not full)
//   mul_start/mul_a/mul_b                : one-cycle start pulse plus held operands
//   mul_done/mul_product                 : level done and product from multiplier
//   res_valid/res_ready/res_product/
//   res_tag/res_err                      : result handshake; err=1 marks a timeout
module mult_issue
  import mult_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [PROD_W-1:0] res_product_q, res_product_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_err_q, res_err_d;

  logic              issue;
  logic              fifo_full, fifo_empty;
  op_t               fifo_head, fifo_in;
  // Occupancy is carried for visibility only; control uses full/empty.
  logic [$clog2(DEPTH):0] unused_fifo_count;

  assign fifo_in  = '{a: in_a, b: in_b, tag: in_tag};
  assign in_ready = !fifo_full;

  mult_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid && in_ready),
    .push_data (fifo_in),
    .pop       (issue),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    tag_d         = tag_q;
    wait_cnt_d    = wait_cnt_q;
    res_valid_d   = res_valid_q && !res_ready;
    res_product_d = res_product_q;
    res_tag_d     = res_tag_q;
    res_err_d     = res_err_q;
    issue         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only issue when the result register will be free, so a finished
        // operation never has to overwrite an unconsumed result.
        if (!fifo_empty && (!res_valid_q || res_ready)) begin
          issue   = 1'b1;
          mul_a_d = fifo_head.a;
          mul_b_d = fifo_head.b;
          tag_d   = fifo_head.tag;
          state_d = ST_START;
        end
      end
      // START and SETTLE ignore mul_done: a level left high by the previous
      // operation must not be taken as this operation's completion.
      ST_START:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          res_valid_d   = 1'b1;
          res_product_d = mul_product;
          res_tag_d     = tag_q;
          res_err_d     = 1'b0;
          wait_cnt_d    = '0;
          state_d       = ST_IDLE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_valid_d   = 1'b1;
          res_product_d = '0;
          res_tag_d     = tag_q;
          res_err_d     = 1'b1;
          wait_cnt_d    = '0;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      tag_q         <= '0;
      wait_cnt_q    <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_tag_q     <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      tag_q         <= tag_d;
      wait_cnt_q    <= wait_cnt_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_tag_q     <= res_tag_d;
      res_err_q     <= res_err_d;
    end
  end

  assign mul_start   = (state_q == ST_START);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign res_valid   = res_valid_q;
  assign res_product = res_product_q;
  assign res_tag     = res_tag_q;
  assign res_err     = res_err_q;

endmodule
